// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port, decode-side head
// port and the branch redirect inputs.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [1:0]        instr_op;
  logic [5:0]        instr_funct;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_op, instr_funct,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_op, instr_funct,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one-outstanding imem requests, 2-entry {pc, word}
// queue feeding decode, flush-and-refetch on branch redirect.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no request outstanding (queue full, or just out of reset)
// ST_WAIT | request for fetch_pc outstanding, ack data is kept
// ST_DROP | stale request outstanding after a redirect, ack data dropped
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_unit_if.master  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [1:0]        count;
  logic [1:0]        cnt_after;
  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_word;
  logic [ADDR_W-1:0] tail_pc;
  logic [DATA_W-1:0] tail_word;

  assign pop    = (count != 2'd0) && bus.instr_ready;
  assign push   = (state == ST_WAIT) && bus.imem_ack && !bus.redirect;
  assign pc_inc = fetch_pc + ADDR_W'(4);
  // A push only happens with count <= 1, so this never wraps past 2.
  assign cnt_after = count + 2'd1 - {1'b0, pop};

  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = head_word;
  assign bus.instr_pc    = head_pc;
  assign bus.instr_op    = head_word[27:26];
  assign bus.instr_funct = head_word[25:20];

  // Fetch sequencing: request issue, PC advance and redirect handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      fetch_pc      <= RESET_PC;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.redirect) begin
            fetch_pc      <= bus.redirect_pc;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= bus.redirect_pc;
            state         <= ST_WAIT;
          end else if (count != 2'd2) begin
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= fetch_pc;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            if (bus.imem_ack) begin
              bus.imem_addr <= bus.redirect_pc;
            end else begin
              // Old address stays on the bus until memory answers.
              state <= ST_DROP;
            end
          end else if (bus.imem_ack) begin
            fetch_pc <= pc_inc;
            if (cnt_after < 2'd2) begin
              bus.imem_addr <= pc_inc;
            end else begin
              bus.imem_req <= 1'b0;
              state        <= ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            if (bus.imem_ack) begin
              bus.imem_addr <= bus.redirect_pc;
              state         <= ST_WAIT;
            end
          end else if (bus.imem_ack) begin
            bus.imem_addr <= fetch_pc;
            state         <= ST_WAIT;
          end
        end
        default: begin
          bus.imem_req <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  // Two-slot queue; slot 0 is always the head presented to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_pc   <= '0;
      head_word <= '0;
      tail_pc   <= '0;
      tail_word <= '0;
    end else if (bus.redirect) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc   <= fetch_pc;
            head_word <= bus.imem_rdata;
          end else begin
            tail_pc   <= fetch_pc;
            tail_word <= bus.imem_rdata;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc   <= tail_pc;
          head_word <= tail_word;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc   <= fetch_pc;
            head_word <= bus.imem_rdata;
          end else begin
            head_pc   <= tail_pc;
            head_word <= tail_word;
            tail_pc   <= fetch_pc;
            tail_word <= bus.imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory returns word == address with a
// programmable ack latency; a scoreboard of expected PCs is checked on every
// decode handshake.
module tb_instr_fetch_unit;
  logic clk;
  logic rst_n;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;
  int lat = 0;
  int req_age;
  logic [31:0] exp_q[$];
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: ack once a request has been waiting lat cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_age <= 0;
    else if (bus.imem_req && !bus.imem_ack) req_age <= req_age + 1;
    else req_age <= 0;
  end
  assign bus.imem_ack   = bus.imem_req && (req_age >= lat);
  assign bus.imem_rdata = bus.imem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: request stability and scoreboard on decode handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_req && !prev_ack) begin
        check("req_held", 32'(bus.imem_req), 32'd1);
        check("addr_stable", bus.imem_addr, prev_addr);
      end
      if (bus.instr_valid && bus.instr_ready) begin
        logic [31:0] e;
        n_xfer++;
        check("unexpected_instr", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("instr_pc", bus.instr_pc, e);
          check("instr", bus.instr, e);
          check("instr_op", 32'(bus.instr_op), 32'(e[27:26]));
          check("instr_funct", 32'(bus.instr_funct), 32'(e[25:20]));
        end
      end
      prev_req  = bus.imem_req;
      prev_ack  = bus.imem_ack;
      prev_addr = bus.imem_addr;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic consume(input int n, output int cyc);
    int target;
    target = n_xfer + n;
    cyc = 0;
    bus.instr_ready = 1'b1;
    while (n_xfer < target && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.instr_ready = 1'b0;
    check("consume_timeout", 32'(n_xfer >= target), 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_age(input int k);
    int b;
    b = 0;
    while (req_age != k && b < 20) begin
      step(1);
      b++;
    end
    check("wait_age_timeout", 32'(req_age == k), 32'd1);
  endtask

  initial begin
    int cyc;
    int b;
    rst_n           = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    lat             = 0;

    // Reset values
    step(1);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'h0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);
    check("rst_instr_op", 32'(bus.instr_op), 32'd0);
    check("rst_instr_funct", 32'(bus.instr_funct), 32'd0);

    // Zero-wait stream
    expect_seq(32'h0, 20);
    rst_n = 1'b1;
    step(1);
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, 32'h0);
    consume(1, cyc);
    check("first_latency", 32'(cyc), 32'd2);
    consume(7, cyc);
    check("stream_rate", 32'(cyc), 32'd7);

    // Backpressure: queue fills, request stops, order preserved
    step(5);
    check("bp_req_off", 32'(bus.imem_req), 32'd0);
    check("bp_valid", 32'(bus.instr_valid), 32'd1);
    check("bp_head", bus.instr_pc, 32'h20);
    consume(6, cyc);

    // Slow memory: one instruction per 4 cycles
    step(6);
    check("fill_req_off", 32'(bus.imem_req), 32'd0);
    lat = 3;
    consume(2, cyc);
    consume(1, cyc);
    consume(3, cyc);
    check("slow_rate", 32'(cyc), 32'd12);
    check("slow_drained", 32'(exp_q.size()), 32'd0);

    // Redirect while idle with a full queue
    step(12);
    check("ri_full_req", 32'(bus.imem_req), 32'd0);
    check("ri_full_valid", 32'(bus.instr_valid), 32'd1);
    lat = 0;
    redirect_to(32'h100);
    check("ri_valid_flushed", 32'(bus.instr_valid), 32'd0);
    check("ri_req", 32'(bus.imem_req), 32'd1);
    check("ri_addr", bus.imem_addr, 32'h100);
    expect_seq(32'h100, 4);
    step(1);
    check("ri_target_valid", 32'(bus.instr_valid), 32'd1);
    check("ri_target_pc", bus.instr_pc, 32'h100);
    consume(4, cyc);

    // Redirect two cycles before a delayed ack
    step(6);
    check("rp_idle", 32'(bus.imem_req), 32'd0);
    lat = 3;
    redirect_to(32'h180);
    check("rp_req", 32'(bus.imem_req), 32'd1);
    check("rp_addr", bus.imem_addr, 32'h180);
    wait_age(1);
    redirect_to(32'h200);
    check("rp_drop_addr", bus.imem_addr, 32'h180);
    b = 0;
    while (!bus.imem_ack && b < 10) begin
      step(1);
      b++;
    end
    check("rp_stale_ack", 32'(bus.imem_ack), 32'd1);
    check("rp_stale_addr", bus.imem_addr, 32'h180);
    step(1);
    check("rp_new_req", 32'(bus.imem_req), 32'd1);
    check("rp_new_addr", bus.imem_addr, 32'h200);
    check("rp_no_stale", 32'(bus.instr_valid), 32'd0);
    expect_seq(32'h200, 2);
    consume(2, cyc);

    // Redirect in the same cycle as the ack
    step(16);
    check("rs_idle", 32'(bus.imem_req), 32'd0);
    redirect_to(32'h180);
    wait_age(3);
    check("rs_ack_now", 32'(bus.imem_ack), 32'd1);
    redirect_to(32'h300);
    check("rs_req", 32'(bus.imem_req), 32'd1);
    check("rs_addr", bus.imem_addr, 32'h300);
    check("rs_no_stale", 32'(bus.instr_valid), 32'd0);
    expect_seq(32'h300, 3);
    consume(3, cyc);

    // Non-zero op/funct fields
    step(16);
    check("of_idle", 32'(bus.imem_req), 32'd0);
    lat = 0;
    redirect_to(32'h0A50_0000);
    expect_seq(32'h0A50_0000, 3);
    consume(3, cyc);

    // PC wraps past the top of the address space
    step(6);
    check("wr_idle", 32'(bus.imem_req), 32'd0);
    redirect_to(32'hFFFF_FFF8);
    expect_seq(32'hFFFF_FFF8, 4);
    consume(4, cyc);

    // Async reset while a request is outstanding
    step(6);
    check("ar_idle", 32'(bus.imem_req), 32'd0);
    lat = 3;
    redirect_to(32'h400);
    b = 0;
    while (!bus.instr_valid && b < 10) begin
      step(1);
      b++;
    end
    check("ar_pre_valid", 32'(bus.instr_valid), 32'd1);
    check("ar_pre_req", 32'(bus.imem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_req_drop", 32'(bus.imem_req), 32'd0);
    check("ar_valid_drop", 32'(bus.instr_valid), 32'd0);
    check("ar_addr_reset", bus.imem_addr, 32'h0);
    prev_req = 1'b0;
    lat      = 0;
    exp_q.delete();
    #1 rst_n = 1'b1;
    expect_seq(32'h0, 3);
    step(1);
    check("ar_restart_req", 32'(bus.imem_req), 32'd1);
    check("ar_restart_addr", bus.imem_addr, 32'h0);
    consume(3, cyc);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the single-cycle controller. Holds the fetch PC, issues one-outstanding requests to instruction memory over a req/ack handshake, and buffers returned words in a 2-entry queue. It presents the head instruction, its PC, and the pre-split Op/funct fields to the decode/controller stage. Redirects from the branch path (PC_Src) flush the queue and restart fetch at the target.

## Interface
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; registered; held until imem_ack
- imem_addr  out  ADDR_W  fetch address; registered; stable while imem_req=1
- imem_ack  in  1  single-cycle acknowledge; imem_rdata valid in the same cycle
- imem_rdata  in  DATA_W  fetched word
- instr_valid  out  1  queue head valid (count != 0)
- instr_ready  in  1  decode stage consumes the head this cycle
- instr  out  DATA_W  queue head word
- instr_pc  out  ADDR_W  address of the queue head
- instr_op  out  2  instr[27:26]
- instr_funct  out  6  instr[25:20]
- redirect  in  1  branch taken; flush and refetch
- redirect_pc  in  ADDR_W  target address, sampled when redirect=1

## Operation
- State: fetch_pc, queue of 2 entries {pc, word}, count (0..2), FSM IDLE / WAIT / DROP.
- Pop: instr_valid && instr_ready. Push: imem_ack in WAIT. Pops and pushes are both allowed in the same cycle.
- IDLE:
  - If count < 2, go to WAIT next cycle with imem_req=1 and imem_addr=fetch_pc.
- WAIT (request outstanding):
  - On imem_ack, push {fetch_pc, imem_rdata} and set fetch_pc += 4 (mod 2^ADDR_W, wraps to 0).
  - Compute count_next = count + 1 - pop. If count_next < 2, stay in WAIT with imem_req=1 and imem_addr=fetch_pc+4 (back-to-back). Otherwise go to IDLE with imem_req=0.
- DROP (stale request outstanding after redirect):
  - Keep imem_req=1 and the old address until imem_ack. Discard the data on ack.
  - Next state is WAIT with imem_addr=fetch_pc (the redirect target).
- Redirect (priority over everything):
  - A pop in the redirect cycle still counts as a transfer.
  - Clear the queue (count=0) and set fetch_pc=redirect_pc.
  - From IDLE, or from WAIT/DROP with an ack in the same cycle: the ack data is discarded. Next cycle is WAIT with imem_req=1 and imem_addr=redirect_pc.
  - From WAIT or DROP without an ack: go to DROP.
- Queue overflow is impossible: a request is only issued while count < 2, and at most one request is outstanding.
- Reset mid-operation aborts any outstanding request immediately (imem_req drops asynchronously). The memory side must tolerate an abandoned request.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC
  - instr_valid=0, instr=0, instr_pc=0, instr_op=0, instr_funct=0
  - count=0, FSM=IDLE
- First request: the first clk edge after rst_n deasserts enters WAIT. imem_req=1 and imem_addr=RESET_PC are visible in the following cycle.
- Zero-wait memory (ack in the same cycle as req), continuous instr_ready=1: one instruction per cycle after the first.
- Fetch-to-decode latency: data pushed at the ack edge gives instr_valid=1 in the next cycle.
- Redirect with no outstanding request: imem_req=1 with redirect_pc is visible 1 cycle after the redirect edge. With zero-wait memory, the target instruction is valid 2 cycles after the redirect.
- Redirect with a pending request: the target request starts the cycle after the stale ack.
- Outputs instr, instr_pc, instr_op and instr_funct are combinational from the queue head registers. They are undefined-but-stable (last value) while instr_valid=0.

## Test plan
- Reset and zero-wait stream: hold imem_ack=imem_req and instr_ready=1, with memory returning the word equal to its address. Required: instr_pc sequence 0,4,8,… one per cycle; instr equals instr_pc; instr_op/instr_funct match bits [27:26]/[25:20].
- Backpressure: hold instr_ready=0 for 5 cycles. Required: count reaches 2, imem_req=0, no lost or duplicated words. Releasing ready resumes in order.
- Slow memory: ack 3 cycles after req. Required: imem_addr stays stable while req=1, and one instruction is delivered per 4 cycles.
- Redirect while idle: redirect=1 with redirect_pc=0x100 while the queue is full. Required: instr_valid=0 next cycle, imem_addr=0x100 next cycle, and the first delivered instr_pc is 0x100.
- Redirect with pending request: redirect to 0x200 two cycles before a delayed ack. Required: the acked data is dropped, the next imem_addr is 0x200, and the stale PC never appears on instr_pc. Repeat with the redirect and the ack in the same cycle.
- Async reset mid-WAIT: pulse rst_n low between clock edges. Required: imem_req=0 and instr_valid=0 immediately, and fetch restarts at RESET_PC.
